// File: rtl/fix2float_norm_pipe.sv
// Streaming signed fixed-point to float converter: magnitude, leading-one search, normalise.
// Define FIX2FLOAT_RNE_EN to round-to-nearest-even in the normalise stage (default: truncate).
module fix2float_norm_pipe #(
  parameter int FIX_WIDTH = 21,
  parameter int FRAC_BITS = 10,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int EXP_BIAS  = 15,
  parameter int POS_WIDTH = $clog2(FIX_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FIX_WIDTH-1:0]           in_fix,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_float,
  output logic                           out_zero,
  output logic                           out_ovf
);
  localparam int PAD_W = 1 << POS_WIDTH;
  localparam int EW2   = EXP_WIDTH + 2;
  localparam int FLT_W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int EXT_W = FIX_WIDTH + MAN_WIDTH + 1;
  localparam logic [EW2-1:0]       EXP_SAT = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'((1 << EXP_WIDTH) - 2);

  // Binary-halving leading-one search over the power-of-two padded magnitude.
  function automatic logic [POS_WIDTH-1:0] lead_one(input logic [FIX_WIDTH-1:0] m);
    logic [PAD_W-1:0]     v;
    logic [POS_WIDTH-1:0] p;
    v = PAD_W'(m);
    p = '0;
    for (int k = POS_WIDTH - 1; k >= 0; k--) begin
      if ((v >> (1 << k)) != '0) begin
        p[k] = 1'b1;
        v    = v >> (1 << k);
      end else begin
        p[k] = 1'b0;
      end
    end
    return p;
  endfunction

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic s1_load, s2_load, s3_load;

  logic                 s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
  logic [FIX_WIDTH-1:0] s1_mag_q, s1_mag_d;
  logic                 s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic [FIX_WIDTH-1:0] s2_mag_q, s2_mag_d;
  logic [POS_WIDTH-1:0] s2_pos_q, s2_pos_d;
  logic [FLT_W-1:0]     s3_float_q, s3_float_d;
  logic                 s3_zero_q, s3_zero_d, s3_ovf_q, s3_ovf_d;

  logic [FIX_WIDTH-1:0] norm;
  logic [EXT_W-1:0]     ext;
  logic [MAN_WIDTH-1:0] man;
  logic [EW2-1:0]       expo;   // two's complement, MSB is the sign
  logic [FLT_W-1:0]     flt;
  logic                 flt_zero, flt_ovf;

  // Bubble-collapsing load enables; a stage advances when empty or its successor advances.
  always_comb begin
    s3_load    = ~s3_valid_q | out_ready;
    s2_load    = ~s2_valid_q | s3_load;
    s1_load    = ~s1_valid_q | s2_load;
    in_ready   = s1_load;
    s1_valid_d = s1_load ? in_valid   : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;
  end

  // Stage 1: sign and magnitude; the most negative input maps exactly to 2^(FIX_WIDTH-1).
  always_comb begin
    if (s1_load && in_valid) begin
      s1_sign_d = in_fix[FIX_WIDTH-1];
      s1_mag_d  = in_fix[FIX_WIDTH-1] ? (FIX_WIDTH'(1'b0) - in_fix) : in_fix;
      s1_zero_d = (in_fix == '0);
    end else begin
      s1_sign_d = s1_sign_q;
      s1_mag_d  = s1_mag_q;
      s1_zero_d = s1_zero_q;
    end
  end

  // Stage 2: leading-one position.
  always_comb begin
    if (s2_load && s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
      s2_mag_d  = s1_mag_q;
      s2_pos_d  = lead_one(s1_mag_q);
    end else begin
      s2_sign_d = s2_sign_q;
      s2_zero_d = s2_zero_q;
      s2_mag_d  = s2_mag_q;
      s2_pos_d  = s2_pos_q;
    end
  end

  // Stage 3 datapath: normalise, optional rounding, then flush/saturate.
  always_comb begin
    norm = s2_mag_q << (POS_WIDTH'(FIX_WIDTH - 1) - s2_pos_q);
    ext  = {norm, {(MAN_WIDTH + 1){1'b0}}};
    man  = MAN_WIDTH'(ext >> FIX_WIDTH);
    expo = EW2'(s2_pos_q) - EW2'(FRAC_BITS) + EW2'(EXP_BIAS);
`ifdef FIX2FLOAT_RNE_EN
    // Guard bit sits just below the mantissa; everything under it is sticky.
    if (ext[FIX_WIDTH-1] && ((|ext[FIX_WIDTH-2:0]) || man[0])) begin
      if (&man) begin
        man  = {MAN_WIDTH{1'b0}};
        expo = expo + EW2'(1);
      end else begin
        man  = man + MAN_WIDTH'(1);
      end
    end else begin
      man = man;
    end
`endif
    if (s2_zero_q) begin
      flt      = {FLT_W{1'b0}};
      flt_zero = 1'b1;
      flt_ovf  = 1'b0;
    end else if (expo[EW2-1] || (expo == '0)) begin
      flt      = {s2_sign_q, {(FLT_W - 1){1'b0}}};
      flt_zero = 1'b1;
      flt_ovf  = 1'b0;
    end else if (expo >= EXP_SAT) begin
      flt      = {s2_sign_q, EXP_MAX, {MAN_WIDTH{1'b1}}};
      flt_zero = 1'b0;
      flt_ovf  = 1'b1;
    end else begin
      flt      = {s2_sign_q, expo[EXP_WIDTH-1:0], man};
      flt_zero = 1'b0;
      flt_ovf  = 1'b0;
    end
  end

  // Stage 3 output register; holds while stalled so out_float stays stable.
  always_comb begin
    if (s3_load && s2_valid_q) begin
      s3_float_d = flt;
      s3_zero_d  = flt_zero;
      s3_ovf_d   = flt_ovf;
    end else begin
      s3_float_d = s3_float_q;
      s3_zero_d  = s3_zero_q;
      s3_ovf_d   = s3_ovf_q;
    end
  end

  // Pipeline state; synchronous reset drops every in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_mag_q   <= '0;
      s2_pos_q   <= '0;
      s3_float_q <= '0;
      s3_zero_q  <= 1'b0;
      s3_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_mag_q   <= s1_mag_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_mag_q   <= s2_mag_d;
      s2_pos_q   <= s2_pos_d;
      s3_float_q <= s3_float_d;
      s3_zero_q  <= s3_zero_d;
      s3_ovf_q   <= s3_ovf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_float = s3_float_q;
  assign out_zero  = s3_zero_q;
  assign out_ovf   = s3_ovf_q;

endmodule

// File: tb/tb_fix2float_norm_pipe.sv
// Scoreboard bench for fix2float_norm_pipe: default instance plus two small-exponent instances
// (FRAC_BITS=0 and FRAC_BITS=12, EXP_WIDTH=4, EXP_BIAS=7) for saturation and flush.
module tb_fix2float_norm_pipe;
  localparam int FW = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall0  = 0;
  int   n_push1 = 0;
  int   n_push2 = 0;
  logic done;

  logic          v0, r0, ov0, or0, z0, f0;
  logic [FW-1:0] x0;
  logic [15:0]   fl0;
  logic [17:0]   e0, held0;
  logic          hold0;
  logic          v1, r1, ov1, or1, z1, f1;
  logic [FW-1:0] x1;
  logic [14:0]   fl1;
  logic [17:0]   e1;
  logic          v2, r2, ov2, or2, z2, f2;
  logic [FW-1:0] x2;
  logic [14:0]   fl2;
  logic [17:0]   e2;
  logic [17:0]   q0[$], q1[$], q2[$];

  fix2float_norm_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_fix(x0),
    .out_valid(ov0), .out_ready(or0), .out_float(fl0), .out_zero(z0), .out_ovf(f0));

  fix2float_norm_pipe #(.FRAC_BITS(0), .EXP_WIDTH(4), .EXP_BIAS(7)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_fix(x1),
    .out_valid(ov1), .out_ready(or1), .out_float(fl1), .out_zero(z1), .out_ovf(f1));

  fix2float_norm_pipe #(.FRAC_BITS(12), .EXP_WIDTH(4), .EXP_BIAS(7)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_fix(x2),
    .out_valid(ov2), .out_ready(or2), .out_float(fl2), .out_zero(z2), .out_ovf(f2));

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got zero=%0b ovf=%0b val=%h, want zero=%0b ovf=%0b val=%h",
               name, got[17], got[16], got[15:0], want[17], want[16], want[15:0]);
    end
  endtask

  // Reference: value-level conversion with integer arithmetic; returns {zero, ovf, float}.
  function automatic logic [17:0] ref_f2f(input logic [FW-1:0] fix, input int frac,
                                          input int ew, input int bias);
    longint sv, mag, full;
    int pos, e;
    logic [15:0] sgn;
`ifdef FIX2FLOAT_RNE_EN
    longint rem, half;
`endif
    sv  = longint'($signed(fix));
    mag = (sv < 0) ? -sv : sv;
    if (mag == 0) return {1'b1, 1'b0, 16'h0000};
    sgn = (sv < 0) ? (16'h0001 << (ew + 10)) : 16'h0000;
    pos = 0;
    for (int p = 0; p < FW; p++) if (mag >= (longint'(1) << p)) pos = p;
    full = (mag << 10) >> pos;
    e    = pos - frac + bias;
`ifdef FIX2FLOAT_RNE_EN
    rem  = (mag << 10) - (full << pos);
    half = (pos > 0) ? (longint'(1) << (pos - 1)) : 0;
    if (pos > 0 && (rem > half || (rem == half && full[0]))) full++;
    if (full == 2048) begin full = 1024; e++; end
`endif
    if (e <= 0) return {1'b1, 1'b0, sgn};
    if (e >= (1 << ew) - 1) return {1'b0, 1'b1, sgn | 16'(((1 << ew) - 2) << 10) | 16'h03FF};
    return {1'b0, 1'b0, sgn | 16'(e << 10) | 16'(full - 1024)};
  endfunction

  function automatic logic [FW-1:0] rand_fix();
    logic [FW-1:0] v;
    v = FW'($urandom);
    case ($urandom_range(0, 3))
      0:       v = v;
      1:       v = FW'($signed(v) >>> $urandom_range(0, FW - 1));
      2:       v = v[0] ? 21'h100000 : 21'h000000;
      default: v = FW'($signed(v) >>> (FW - 6));
    endcase
    return v;
  endfunction

  // Scoreboard push on every accepted input.
  always @(negedge clk) begin
    if (!rst && v0 && r0) q0.push_back(e0);
    if (!rst && v1 && r1) begin q1.push_back(e1); n_push1++; end
    if (!rst && v2 && r2) begin q2.push_back(e2); n_push2++; end
  end

  // Channel 0 monitor: compare on transfer, and check stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold0 <= 1'b0;
    end else begin
      if (hold0 && ov0) check("stall_hold", {z0, f0, fl0}, held0);
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ch0_extra: got output %h, want no output", fl0);
        end else begin
          check("ch0_data", {z0, f0, fl0}, q0.pop_front());
        end
      end
      hold0 <= ov0 && !or0;
      held0 <= {z0, f0, fl0};
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ch1_extra: got output %h, want no output", fl1);
      end else check("ch1_data", {z1, f1, 1'b0, fl1}, q1.pop_front());
    end
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ch2_extra: got output %h, want no output", fl2);
      end else check("ch2_data", {z2, f2, 1'b0, fl2}, q2.pop_front());
    end
  end

  task automatic send0(input logic [FW-1:0] val, input logic [17:0] ex);
    int w;
    w  = 0;
    v0 = 1'b1; x0 = val; e0 = ex;
    @(negedge clk);
    while (!r0 && w < 200) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    v0 = 1'b0;
    stall0 += w;
    if (w >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL send0_timeout: got in_ready=0 for %0d cycles, want 1", w);
    end
  endtask

  task automatic send_alt(input logic [FW-1:0] a, input logic [17:0] ea,
                          input logic [FW-1:0] b, input logic [17:0] eb);
    v1 = 1'b1; x1 = a; e1 = ea;
    v2 = 1'b1; x2 = b; e2 = eb;
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic lat_check(input logic [FW-1:0] val, input logic [17:0] ex);
    int lat;
    v0 = 1'b1; x0 = val; e0 = ex;
    @(posedge clk); #1;
    v0  = 1'b0;
    lat = 1;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 18'(lat), 18'd3);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("drain_q0", 18'(q0.size()), 18'd0);
    check("drain_q1", 18'(q1.size()), 18'd0);
    check("drain_q2", 18'(q2.size()), 18'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] dv[9];
    logic [17:0]   dx[9];
    logic [FW-1:0] x;
    int            n_alt;

    dv[0] = 21'h000400; dx[0] = {2'b00, 16'h3C00};
    dv[1] = 21'h1FFC00; dx[1] = {2'b00, 16'hBC00};
    dv[2] = 21'h000001; dx[2] = {2'b00, 16'h1400};
    dv[3] = 21'h000000; dx[3] = {2'b10, 16'h0000};
    dv[4] = 21'h100000; dx[4] = {2'b00, 16'hE400};
`ifdef FIX2FLOAT_RNE_EN
    dv[5] = 21'h0FFFFF; dx[5] = {2'b00, 16'h6400};
    dv[7] = 21'h000803; dx[7] = {2'b00, 16'h4002};
`else
    dv[5] = 21'h0FFFFF; dx[5] = {2'b00, 16'h63FF};
    dv[7] = 21'h000803; dx[7] = {2'b00, 16'h4001};
`endif
    dv[6] = 21'h000801; dx[6] = {2'b00, 16'h4000};
    dv[8] = 21'h1FFFFF; dx[8] = {2'b00, 16'h9400};

    rst = 1'b1; done = 1'b0;
    v0 = 1'b0; x0 = '0; e0 = '0; or0 = 1'b1;
    v1 = 1'b0; x1 = '0; e1 = '0; or1 = 1'b1;
    v2 = 1'b0; x2 = '0; e2 = '0; or2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 18'(ov0), 18'd0);
    check("rst_out_data", {z0, f0, fl0}, 18'd0);
    check("rst_in_ready", 18'(r0), 18'd1);

    lat_check(21'h000400, {2'b00, 16'h3C00});
    for (int i = 0; i < 9; i++) send0(dv[i], dx[i]);

    stall0 = 0;
    for (int i = 0; i < 20; i++) begin
      x = rand_fix();
      send0(x, ref_f2f(x, 10, 5, 15));
    end
    check("throughput_stalls", 18'(stall0), 18'd0);

    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          x = rand_fix();
          send0(x, ref_f2f(x, 10, 5, 15));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; or0 = 1'($urandom_range(0, 1)); end
      end
    join
    or0 = 1'b1;
    drain();

    send_alt(21'h000400, {2'b01, 16'h3BFF}, 21'h000001, {2'b10, 16'h0000});
    send_alt(21'h1FFC00, {2'b01, 16'h7BFF}, 21'h1FFFFF, {2'b10, 16'h4000});
    send_alt(21'h000080, {2'b00, 16'h3800}, 21'h000040, {2'b00, 16'h0400});
    send_alt(21'h000100, {2'b01, 16'h3BFF}, 21'h100000, {2'b01, 16'h7BFF});
    send_alt(21'h000001, {2'b00, 16'h1C00}, 21'h080000, {2'b00, 16'h3800});
    n_alt = 5;
    for (int i = 0; i < 15; i++) begin
      x = rand_fix();
      send_alt(x, ref_f2f(x, 0, 4, 7), ~x, ref_f2f(~x, 12, 4, 7));
      n_alt++;
    end
    drain();
    check("ch1_accepted", 18'(n_push1), 18'(n_alt));
    check("ch2_accepted", 18'(n_push2), 18'(n_alt));

    or0 = 1'b0;
    send0(21'h000400, {2'b00, 16'h3C00});
    send0(21'h000001, {2'b00, 16'h1400});
    send0(21'h1FFC00, {2'b00, 16'hBC00});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    check("midrst_out_valid", 18'(ov0), 18'd0);
    check("midrst_out_data", {z0, f0, fl0}, 18'd0);
    check("midrst_in_ready", 18'(r0), 18'd1);
    or0 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lat_check(21'h1FFC00, {2'b00, 16'hBC00});
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
